// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the loadable down-counter/timer: FSM state encoding and
// the one-shot/periodic mode values sampled on load.
package down_counter_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable WIDTH-bit down-counter: counts a programmed value to zero, pulses
// terminal for one cycle, and optionally reloads itself for periodic operation.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             terminal_q, terminal_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    mode_d     = mode_q;
    terminal_d = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      mode_d   = mode;
      state_d  = (load_value != CNT_ZERO) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && enable) begin
      if (count_q > CNT_ONE) begin
        count_d = count_q - CNT_ONE;
      end else begin
        // Terminal count: RUN is never entered with zero, so this is count == 1.
        terminal_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          count_d = reload_q;
        end else begin
          count_d = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= CNT_ZERO;
      reload_q   <= CNT_ZERO;
      mode_q     <= MODE_ONESHOT;
      terminal_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      mode_q     <= mode_d;
      terminal_q <= terminal_d;
    end
  end

  assign counter_out = count_q;
  assign terminal    = terminal_q;
  assign busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, one-shot, periodic, enable gaps,
// load priority, abort and full-range load, with hand-computed expectations.
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] counter_out;
  logic             terminal;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .mode        (mode),
    .counter_out (counter_out),
    .terminal    (terminal),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock edge, then sample 1 time unit later and check all three outputs.
  task automatic step(input string tag, input int exp_cnt, input bit exp_term, input bit exp_busy);
    @(posedge clock);
    #1;
    $display("[%0t] %s: cnt=%0d term=%0b busy=%0b", $time, tag, counter_out, terminal, busy);
    check({tag, ".cnt"},  32'(counter_out), 32'(exp_cnt));
    check({tag, ".term"}, 32'(terminal),    32'(exp_term));
    check({tag, ".busy"}, 32'(busy),        32'(exp_busy));
  endtask

  task automatic do_load(input int val, input bit md, input bit en);
    load       = 1'b1;
    load_value = WIDTH'(val);
    mode       = md;
    enable     = en;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst.cnt",  32'(counter_out), 32'd0);
    check("rst.term", 32'(terminal),    32'd0);
    check("rst.busy", 32'(busy),        32'd0);
    reset = 1'b0;

    // Reset mid-count at counter_out=5 while RUN
    do_load(5, 1'b0, 1'b0);
    step("mid.load", 5, 1'b0, 1'b1);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid.rst.cnt",  32'(counter_out), 32'd0);
    check("mid.rst.busy", 32'(busy),        32'd0);
    check("mid.rst.term", 32'(terminal),    32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // One-shot: 3,2,1,0 with terminal on reaching 0
    do_load(3, 1'b0, 1'b1);
    step("os.load", 3, 1'b0, 1'b1);
    load = 1'b0;
    step("os.2", 2, 1'b0, 1'b1);
    step("os.1", 1, 1'b0, 1'b1);
    step("os.0", 0, 1'b1, 1'b0);
    step("os.hold", 0, 1'b0, 1'b0);
    step("os.hold2", 0, 1'b0, 1'b0);

    // Periodic: mode input changed after load must not matter
    do_load(3, 1'b1, 1'b1);
    step("per.load", 3, 1'b0, 1'b1);
    load = 1'b0;
    mode = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      int ph;
      ph = i % 3;
      step($sformatf("per.%0d", i), (ph == 0) ? 3 : 3 - ph, ph == 0, 1'b1);
    end

    // Enable gaps: 4,3,3,3,2
    do_load(4, 1'b0, 1'b0);
    step("gap.load", 4, 1'b0, 1'b1);
    load = 1'b0;
    enable = 1'b1; step("gap.e1", 3, 1'b0, 1'b1);
    enable = 1'b0; step("gap.e0a", 3, 1'b0, 1'b1);
    enable = 1'b0; step("gap.e0b", 3, 1'b0, 1'b1);
    enable = 1'b1; step("gap.e1b", 2, 1'b0, 1'b1);

    // Load priority over terminal condition at count 1
    step("pri.to1", 1, 1'b0, 1'b1);
    do_load(6, 1'b0, 1'b1);
    step("pri.load", 6, 1'b0, 1'b1);
    load = 1'b0;
    step("pri.5", 5, 1'b0, 1'b1);

    // Abort with load 0; IDLE ignores enable
    do_load(0, 1'b1, 1'b1);
    step("abort", 0, 1'b0, 1'b0);
    load = 1'b0;
    step("abort.idle1", 0, 1'b0, 1'b0);
    step("abort.idle2", 0, 1'b0, 1'b0);

    // Full-range load: terminal exactly 15 edges after the load edge
    do_load(15, 1'b0, 1'b1);
    step("max.load", 15, 1'b0, 1'b1);
    load = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step($sformatf("max.%0d", i), 15 - i, i == 15, i < 15);
    end
    step("max.after", 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
